// File: rtl/tx_rate_ctrl.sv
// Read-rate scheduler for a rate-matching FIFO: primes, reads at a fixed cadence,
// drains on request and flags underflow with a saturating event counter.
module tx_rate_ctrl #(
    parameter int DIVIDER = 120,
    parameter int ERR_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_prog_full,
    input  logic             i_empty,
    input  logic             i_clear_err,
    output logic             o_rd_en,
    output logic             o_running,
    output logic [1:0]       o_state,
    output logic             o_underflow,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(DIVIDER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_wrap;
    logic             strobe;
    logic             rd_nxt;
    logic             uf_event;

    assign strobe   = ((state == RUN) || (state == DRAIN)) && (cnt == CNT_LAST);
    assign cnt_wrap = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    assign o_state  = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rd_nxt    = 1'b0;
        uf_event  = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) state_nxt = PRIME;
            end
            PRIME: begin
                if (!i_enable)        state_nxt = IDLE;
                else if (i_prog_full) state_nxt = RUN;
            end
            RUN: begin
                // an underflow on the strobe outranks a simultaneous drain request
                if (strobe && i_empty) begin
                    uf_event  = 1'b1;
                    state_nxt = PRIME;
                end else begin
                    cnt_nxt = cnt_wrap;
                    rd_nxt  = strobe;
                    if (!i_enable) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // empty at the strobe is the normal end of a drain
                if (strobe && i_empty) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_wrap;
                    rd_nxt  = strobe;
                    if (i_enable) state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            o_rd_en     <= 1'b0;
            o_running   <= 1'b0;
            o_underflow <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_rd_en   <= rd_nxt;
            o_running <= (state_nxt == RUN) || (state_nxt == DRAIN);
            if (i_clear_err) begin
                o_underflow <= 1'b0;
                o_err_cnt   <= '0;
            end else if (uf_event) begin
                o_underflow <= 1'b1;
                if (o_err_cnt != ERR_MAX) o_err_cnt <= o_err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_rate_ctrl.sv
// Bench for tx_rate_ctrl: expected read-strobe cycles are queued as stimulus is
// applied and matched against every o_rd_en pulse the DUT produces.
module tb_tx_rate_ctrl;

    localparam int DIV = 120;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_prog_full = 1'b0;
    logic       i_empty = 1'b0;
    logic       i_clear_err = 1'b0;
    logic       o_rd_en;
    logic       o_running;
    logic [1:0] o_state;
    logic       o_underflow;
    logic [7:0] o_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int npulse = 0;
    int t_run = 0;
    int exp_q[$];

    tx_rate_ctrl #(.DIVIDER(DIV), .ERR_W(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_prog_full (i_prog_full),
        .i_empty     (i_empty),
        .i_clear_err (i_clear_err),
        .o_rd_en     (o_rd_en),
        .o_running   (o_running),
        .o_state     (o_state),
        .o_underflow (o_underflow),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // scoreboard: every pulse must match the next queued cycle
    always @(negedge i_clk) begin
        if (!i_reset && o_rd_en) begin
            npulse = npulse + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL rd_en_unexpected at cycle %0d, required no pulse", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    errors = errors + 1;
                    $display("FAIL rd_en_timing got cycle %0d required %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        checks += 5;
        if (o_rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en got %b exp 0", o_rd_en); end
        if (o_running !== 1'b0)   begin errors++; $display("FAIL reset_running got %b exp 0", o_running); end
        if (o_state !== 2'd0)     begin errors++; $display("FAIL reset_state got %0d exp 0", o_state); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", o_underflow); end
        if (o_err_cnt !== 8'd0)   begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", o_err_cnt); end
    endtask

    task automatic test_prime_run();
        int n0;
        i_enable = 1'b1;
        tick();
        checks += 2;
        if (o_state !== 2'd1)   begin errors++; $display("FAIL prime_state got %0d exp 1", o_state); end
        if (o_running !== 1'b0) begin errors++; $display("FAIL prime_running got %b exp 0", o_running); end
        repeat (49) tick();
        checks++;
        if (o_state !== 2'd1) begin errors++; $display("FAIL prime_hold_state got %0d exp 1", o_state); end
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        for (int k = 1; k <= 10; k++) exp_q.push_back(t_run + k * DIV);
        n0 = npulse;
        tick();
        i_prog_full = 1'b0;
        checks += 2;
        if (o_state !== 2'd2)   begin errors++; $display("FAIL run_state got %0d exp 2", o_state); end
        if (o_running !== 1'b1) begin errors++; $display("FAIL run_running got %b exp 1", o_running); end
        while (cyc < t_run + 10 * DIV) tick();
        @(negedge i_clk);
        #1;
        checks += 2;
        if (exp_q.size() != 0)    begin errors++; $display("FAIL run_missing_pulses got %0d left exp 0", exp_q.size()); end
        if (npulse - n0 != 10)    begin errors++; $display("FAIL run_pulse_count got %0d exp 10", npulse - n0); end
    endtask

    task automatic test_underflow();
        int e;
        e = t_run + DIV * ((cyc - t_run) / DIV + 1);
        i_empty = 1'b1;
        while (cyc < e - 1) tick();
        checks++;
        if (o_state !== 2'd2) begin errors++; $display("FAIL uf_pre_state got %0d exp 2", o_state); end
        tick();
        checks += 4;
        if (o_state !== 2'd1)     begin errors++; $display("FAIL uf_state got %0d exp 1", o_state); end
        if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", o_underflow); end
        if (o_err_cnt !== 8'd1)   begin errors++; $display("FAIL uf_err_cnt got %0d exp 1", o_err_cnt); end
        if (o_rd_en !== 1'b0)     begin errors++; $display("FAIL uf_rd_en got %b exp 0", o_rd_en); end
        i_empty = 1'b0;
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        exp_q.push_back(t_run + DIV);
        tick();
        i_prog_full = 1'b0;
        checks++;
        if (o_state !== 2'd2) begin errors++; $display("FAIL uf_rerun_state got %0d exp 2", o_state); end
        while (cyc < t_run + DIV) tick();
        @(negedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL uf_rerun_pulse got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_drain();
        int n0;
        n0 = npulse;
        i_enable = 1'b0;
        i_clear_err = 1'b1;
        for (int k = 2; k <= 4; k++) exp_q.push_back(t_run + k * DIV);
        tick();
        i_clear_err = 1'b0;
        checks += 4;
        if (o_state !== 2'd3)     begin errors++; $display("FAIL drain_state got %0d exp 3", o_state); end
        if (o_running !== 1'b1)   begin errors++; $display("FAIL drain_running got %b exp 1", o_running); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL clear_flag got %b exp 0", o_underflow); end
        if (o_err_cnt !== 8'd0)   begin errors++; $display("FAIL clear_err_cnt got %0d exp 0", o_err_cnt); end
        while (cyc < t_run + 4 * DIV) tick();
        i_empty = 1'b1;
        while (cyc < t_run + 5 * DIV - 1) tick();
        checks++;
        if (o_state !== 2'd3) begin errors++; $display("FAIL drain_hold_state got %0d exp 3", o_state); end
        tick();
        checks += 5;
        if (o_state !== 2'd0)     begin errors++; $display("FAIL drain_end_state got %0d exp 0", o_state); end
        if (o_running !== 1'b0)   begin errors++; $display("FAIL drain_end_running got %b exp 0", o_running); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow got %b exp 0", o_underflow); end
        if (npulse - n0 != 3)     begin errors++; $display("FAIL drain_pulse_count got %0d exp 3", npulse - n0); end
        if (exp_q.size() != 0)    begin errors++; $display("FAIL drain_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        i_empty = 1'b0;
        i_enable = 1'b1;
        tick();
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        tick();
        i_prog_full = 1'b0;
        checks++;
        if (o_state !== 2'd2) begin errors++; $display("FAIL sim_run_state got %0d exp 2", o_state); end
        while (cyc < t_run + DIV - 1) tick();
        i_enable = 1'b0;
        i_empty = 1'b1;
        tick();
        checks += 3;
        if (o_state !== 2'd1)     begin errors++; $display("FAIL sim_enfall_state got %0d exp 1", o_state); end
        if (o_underflow !== 1'b1) begin errors++; $display("FAIL sim_enfall_flag got %b exp 1", o_underflow); end
        if (o_err_cnt !== 8'd1)   begin errors++; $display("FAIL sim_enfall_err_cnt got %0d exp 1", o_err_cnt); end
        i_enable = 1'b1;
        i_empty = 1'b0;
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        tick();
        i_prog_full = 1'b0;
        while (cyc < t_run + DIV - 1) tick();
        i_empty = 1'b1;
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        i_empty = 1'b0;
        checks += 3;
        if (o_state !== 2'd1)     begin errors++; $display("FAIL sim_clr_state got %0d exp 1", o_state); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL sim_clr_flag got %b exp 0", o_underflow); end
        if (o_err_cnt !== 8'd0)   begin errors++; $display("FAIL sim_clr_err_cnt got %0d exp 0", o_err_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_err;
        for (int i = 0; i < 300; i++) begin
            i_empty = 1'b0;
            i_prog_full = 1'b1;
            tick();
            i_prog_full = 1'b0;
            i_empty = 1'b1;
            repeat (DIV) tick();
            exp_err = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            checks++;
            if (o_state !== 2'd1 || o_err_cnt !== exp_err) begin
                errors++;
                $display("FAIL sat_step%0d got state %0d cnt %0d exp state 1 cnt %0d", i, o_state, o_err_cnt, exp_err);
            end
        end
        i_empty = 1'b0;
        checks += 2;
        if (o_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", o_err_cnt); end
        if (o_underflow !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", o_underflow); end
    endtask

    task automatic test_async_reset();
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        tick();
        i_prog_full = 1'b0;
        while (cyc < t_run + DIV) tick();
        checks++;
        if (o_rd_en !== 1'b1) begin errors++; $display("FAIL ar_pulse_before got %b exp 1", o_rd_en); end
        #2;
        i_reset = 1'b1;
        #1;
        checks += 5;
        if (o_rd_en !== 1'b0)     begin errors++; $display("FAIL ar_rd_en got %b exp 0", o_rd_en); end
        if (o_running !== 1'b0)   begin errors++; $display("FAIL ar_running got %b exp 0", o_running); end
        if (o_state !== 2'd0)     begin errors++; $display("FAIL ar_state got %0d exp 0", o_state); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL ar_underflow got %b exp 0", o_underflow); end
        if (o_err_cnt !== 8'd0)   begin errors++; $display("FAIL ar_err_cnt got %0d exp 0", o_err_cnt); end
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        repeat (2 * DIV) tick();
        checks += 2;
        if (o_state !== 2'd1)   begin errors++; $display("FAIL ar_wait_state got %0d exp 1", o_state); end
        if (o_running !== 1'b0) begin errors++; $display("FAIL ar_wait_running got %b exp 0", o_running); end
        i_prog_full = 1'b1;
        t_run = cyc + 1;
        exp_q.push_back(t_run + DIV);
        tick();
        i_prog_full = 1'b0;
        while (cyc < t_run + DIV) tick();
        @(negedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ar_recover_pulse got %0d left exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_underflow();
        test_drain();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
